// File: rtl/lc3_sim_pkg.sv
// Shared state encodings and default parameters for the reset/run sequencer.
// Pure declarations: no latency, no backpressure.
package lc3_sim_pkg;

  typedef enum logic [2:0] {
    ST_PRE     = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } rseq_state_t;

  localparam int DEF_PRE_CYCLES     = 5;
  localparam int DEF_PULSE_CYCLES   = 1;
  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_STAGGER        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 250;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority), enable, and saturation at all ones.
// Latency: count visible one edge after enable. No backpressure; clear always wins.
module sat_counter
  import lc3_sim_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_run_sequencer.sv
// Power-on reset pulse with staggered per-channel release, then a run-cycle counter and watchdog.
// Latency: all outputs registered; halt/timeout reach o_Done on the sampling edge. No backpressure.
// Optional RSEQ_WATCHDOG_EN builds the run watchdog; otherwise o_Timeout is tied low.
module reset_run_sequencer
  import lc3_sim_pkg::*;
#(
  parameter int PRE_CYCLES     = DEF_PRE_CYCLES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int STAGGER        = DEF_STAGGER,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic              i_Halt,
  output logic [NUM_CH-1:0] o_Ch_Reset,
  output logic              o_Run,
  output logic [CNT_W-1:0]  o_Cycle_Count,
  output logic              o_Done,
  output logic              o_Timeout,
  output logic [2:0]        o_State
);

  localparam int LAST_REL = (NUM_CH - 1) * STAGGER;

  rseq_state_t       state_q;
  logic [NUM_CH-1:0] ch_reset_q;
  logic              run_q;
  logic              done_q;
  logic [CNT_W-1:0]  phase_q;
  logic [CNT_W-1:0]  phase_next;
  logic [CNT_W-1:0]  run_cnt_q;
  logic              ph_clr, ph_en;
  logic              run_clr, run_en;
  logic              restart;
  logic              rel_done;
  logic              wd_hit;

  // Channel k stays held while fewer than k*STAGGER release cycles have elapsed.
  function automatic logic [NUM_CH-1:0] held_mask(input logic [CNT_W-1:0] n);
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m[k] = ((k * STAGGER) > int'(n));
    end
    return m;
  endfunction

  assign restart    = i_Start && (state_q != ST_PRE);
  assign phase_next = phase_q + CNT_W'(1);
  assign rel_done   = (int'(phase_next) >= LAST_REL);

`ifdef RSEQ_WATCHDOG_EN
  logic timeout_q;
  assign wd_hit    = (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_Timeout = timeout_q;
`else
  assign wd_hit    = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  always_comb begin
    ph_clr = 1'b1;
    ph_en  = 1'b0;
    case (state_q)
      ST_PRE: begin
        if (phase_q != CNT_W'(PRE_CYCLES)) begin
          ph_clr = 1'b0;
          ph_en  = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (phase_q != CNT_W'(PULSE_CYCLES - 1)) begin
          ph_clr = 1'b0;
          ph_en  = 1'b1;
        end
      end
      ST_RELEASE: begin
        ph_clr = 1'b0;
        ph_en  = 1'b1;
      end
      default: begin
        ph_clr = 1'b1;
        ph_en  = 1'b0;
      end
    endcase
    if (restart) begin
      ph_clr = 1'b1;
    end
  end

  // Run counter is held at zero until RUN and freezes on the exiting edge.
  assign run_clr = restart || (state_q == ST_PRE) || (state_q == ST_ASSERT) ||
                   (state_q == ST_RELEASE);
  assign run_en  = (state_q == ST_RUN) && !i_Halt && !wd_hit;

  sat_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk (i_CLK),
    .rst (i_Reset),
    .clr (ph_clr),
    .en  (ph_en),
    .q   (phase_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk (i_CLK),
    .rst (i_Reset),
    .clr (run_clr),
    .en  (run_en),
    .q   (run_cnt_q)
  );

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_PRE;
      ch_reset_q <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef RSEQ_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else if (restart) begin
      state_q    <= ST_PRE;
      ch_reset_q <= '1;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef RSEQ_WATCHDOG_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_PRE: begin
          if (phase_q == CNT_W'(PRE_CYCLES)) begin
            state_q    <= ST_ASSERT;
            ch_reset_q <= '1;
          end
        end
        ST_ASSERT: begin
          if (phase_q == CNT_W'(PULSE_CYCLES - 1)) begin
            ch_reset_q <= held_mask('0);
            if (LAST_REL == 0) begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          ch_reset_q <= held_mask(phase_next);
          if (rel_done) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_Halt) begin
            state_q <= ST_DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end else if (wd_hit) begin
            state_q   <= ST_DONE;
            run_q     <= 1'b0;
            done_q    <= 1'b1;
`ifdef RSEQ_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_PRE;
        end
      endcase
    end
  end

  assign o_Ch_Reset    = ch_reset_q;
  assign o_Run         = run_q;
  assign o_Done        = done_q;
  assign o_Cycle_Count = run_cnt_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_reset_run_sequencer.sv
// Directed bench for reset_run_sequencer with default parameters; follows RSEQ_WATCHDOG_EN of the build.
module tb_reset_run_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic [1:0]  ch_reset;
  logic        run;
  logic [15:0] cycle_count;
  logic        done;
  logic        timeout;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  reset_run_sequencer #(
    .PRE_CYCLES     (5),
    .PULSE_CYCLES   (1),
    .NUM_CH         (2),
    .STAGGER        (2),
    .TIMEOUT_CYCLES (250),
    .CNT_W          (16)
  ) dut (
    .i_CLK         (clk),
    .i_Reset       (rst),
    .i_Start       (start),
    .i_Halt        (halt),
    .o_Ch_Reset    (ch_reset),
    .o_Run         (run),
    .o_Cycle_Count (cycle_count),
    .o_Done        (done),
    .o_Timeout     (timeout),
    .o_State       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_count(input int target, input int budget);
    int n;
    n = 0;
    while ((int'(cycle_count) != target) && (n < budget)) begin
      tick();
      n++;
    end
    check("wait_count", int'(cycle_count), target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    #23;
    check("rst_ch", 32'(ch_reset), 0);
    check("rst_run", 32'(run), 0);
    check("rst_cnt", 32'(cycle_count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tmo", 32'(timeout), 0);
    check("rst_state", 32'(state), 0);

    // Power-on sequence, E0 is the edge at t=25
    rst = 1'b0;
    tick_n(5);
    check("e4_ch", 32'(ch_reset), 0);
    check("e4_state", 32'(state), 0);
    tick();
    check("e5_ch", 32'(ch_reset), 3);
    check("e5_state", 32'(state), 1);
    tick();
    check("e6_ch", 32'(ch_reset), 2);
    check("e6_state", 32'(state), 2);
    tick();
    check("e7_ch", 32'(ch_reset), 2);
    check("e7_run", 32'(run), 0);
    tick();
    check("e8_ch", 32'(ch_reset), 0);
    check("e8_run", 32'(run), 1);
    check("e8_cnt", 32'(cycle_count), 0);
    check("e8_state", 32'(state), 3);

    // Halt while the count reads 40
    tick_n(40);
    check("pre_halt_cnt", 32'(cycle_count), 40);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_done", 32'(done), 1);
    check("halt_cnt", 32'(cycle_count), 40);
    check("halt_tmo", 32'(timeout), 0);
    check("halt_run", 32'(run), 0);
    check("halt_state", 32'(state), 4);
    halt = 1'b1;
    tick_n(3);
    halt = 1'b0;
    check("done_hold_cnt", 32'(cycle_count), 40);
    check("done_hold_done", 32'(done), 1);

    // Restart from DONE, then run with no halt
    pulse_start();
    check("rs_ch", 32'(ch_reset), 3);
    check("rs_state", 32'(state), 0);
    check("rs_done", 32'(done), 0);
    check("rs_cnt", 32'(cycle_count), 0);
    tick_n(9);
    check("rs_run", 32'(run), 1);
    check("rs_ch0", 32'(ch_reset), 0);
    wait_count(249, 400);
    tick();
`ifdef RSEQ_WATCHDOG_EN
    check("wd_done", 32'(done), 1);
    check("wd_tmo", 32'(timeout), 1);
    check("wd_cnt", 32'(cycle_count), 249);
    check("wd_state", 32'(state), 4);
`else
    check("nowd_cnt", 32'(cycle_count), 250);
    check("nowd_done", 32'(done), 0);
    check("nowd_tmo", 32'(timeout), 0);
    wait_count(65535, 70000);
    tick_n(3);
    check("sat_cnt", 32'(cycle_count), 65535);
    check("sat_run", 32'(run), 1);
    check("sat_done", 32'(done), 0);
`endif

    // Halt on the same cycle the watchdog would fire
    pulse_start();
    wait_count(249, 400);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("tie_done", 32'(done), 1);
    check("tie_tmo", 32'(timeout), 0);
    check("tie_cnt", 32'(cycle_count), 249);

    // Start during RELEASE after relative edge 7
    pulse_start();
    tick_n(7);
    check("rel_ch", 32'(ch_reset), 2);
    check("rel_state", 32'(state), 2);
    pulse_start();
    check("rel_rs_ch", 32'(ch_reset), 3);
    check("rel_rs_state", 32'(state), 0);
    tick_n(2);
    pulse_start();
    check("pre_start_state", 32'(state), 0);
    tick_n(2);
    check("rep5_state", 32'(state), 0);
    check("rep5_ch", 32'(ch_reset), 3);
    tick();
    check("rep6_state", 32'(state), 1);
    tick();
    check("rep7_ch", 32'(ch_reset), 2);
    check("rep7_state", 32'(state), 2);
    tick_n(2);
    check("rep9_ch", 32'(ch_reset), 0);
    check("rep9_run", 32'(run), 1);
    check("rep9_cnt", 32'(cycle_count), 0);

    // Asynchronous reset between edges during RUN
    tick_n(10);
    check("pre_ar_cnt", 32'(cycle_count), 10);
    #3;
    rst = 1'b1;
    #1;
    check("ar_run", 32'(run), 0);
    check("ar_cnt", 32'(cycle_count), 0);
    check("ar_state", 32'(state), 0);
    check("ar_ch", 32'(ch_reset), 0);
    check("ar_done", 32'(done), 0);
    #2;
    rst = 1'b0;
    tick_n(5);
    check("ar_e4_ch", 32'(ch_reset), 0);
    tick();
    check("ar_e5_ch", 32'(ch_reset), 3);
    tick();
    check("ar_e6_ch", 32'(ch_reset), 2);
    tick_n(2);
    check("ar_e8_ch", 32'(ch_reset), 0);
    check("ar_e8_run", 32'(run), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/reset_run_sequencer.md
# reset_run_sequencer

Synthesizable, parametrised power-on reset and run controller for the LC-3 datapath and its test harnesses. After power-up it waits a programmable delay and drives a timed reset pulse onto several channels, releasing each channel in a staggered order. It then counts run cycles until the core reports halt or a watchdog limit expires. It sits between the top-level clock/reset and the `i_Reset` inputs of the datapath, memory controller and peripherals, so benches and FPGA builds share one sequencing block.

## Interface
- PRE_CYCLES, 5: idle cycles after `i_Reset` release before the pulse begins (≥1).
- PULSE_CYCLES, 1: cycles during which all channels are asserted together (≥1).
- NUM_CH, 2: number of reset channels (1–8).
- STAGGER, 2: cycles between releases of successive channels (≥0).
- TIMEOUT_CYCLES, 250: watchdog limit in run cycles (< 2^CNT_W).
- CNT_W, 16: width of the cycle counter.
- i_CLK, input, 1: single system clock; everything is rising-edge.
- i_Reset, input, 1: asynchronous, active-high master reset.
- i_Start, input, 1: re-triggers the full sequence.
- i_Halt, input, 1: core reports halt; sampled only in RUN.
- o_Ch_Reset, output, NUM_CH: per-channel reset; bit 0 is released first.
- o_Run, output, 1: high while in RUN.
- o_Cycle_Count, output, CNT_W: number of run cycles elapsed.
- o_Done, output, 1: run finished; sticky.
- o_Timeout, output, 1: the run ended on the watchdog; sticky.
- o_State, output, 3: current FSM state, for debug.

## Operation
- Clocking and reset are fixed: one clock (`i_CLK`); `i_Reset` is asynchronous and active-high.
- All outputs are registered.
- Reset values: `o_Ch_Reset`=0, `o_Run`=0, `o_Cycle_Count`=0, `o_Done`=0, `o_Timeout`=0, state=PRE.
- FSM states:
  - PRE(0): count up to PRE_CYCLES, then go to ASSERT.
  - ASSERT(1): `o_Ch_Reset` is all ones for PULSE_CYCLES, then go to RELEASE.
  - RELEASE(2): channel k deasserts k·STAGGER cycles after channel 0. Go to RUN on the edge the last channel deasserts.
  - RUN(3): `o_Run`=1 and the counter increments each cycle.
  - DONE(4): `o_Run`=0; `o_Done` and `o_Timeout` hold.
- Leaving RUN:
  - `i_Halt`=1 → DONE, with `o_Done`=1.
  - Counter = TIMEOUT_CYCLES−1 → DONE, with `o_Done`=1 and `o_Timeout`=1.
  - If halt and timeout occur on the same cycle, halt wins and `o_Timeout` stays 0.
- `i_Start`=1 in any state except PRE:
  - Next state is PRE.
  - `o_Done`, `o_Timeout` and the counter clear.
  - `o_Ch_Reset` is forced to all ones. Mid-sequence restarts never leave a channel released while an earlier channel is held.
- `i_Start` in PRE is ignored.
- With STAGGER=0, all channels release together and RUN is entered after the ASSERT phase.
- The counter saturates at 2^CNT_W−1 and never wraps.
- The NUM_CH=1 degenerate case requires no special handling.
- `i_Halt` outside RUN has no effect.

## Timing
- E0 is the first rising edge after `i_Reset` falls. With default parameters:
  - `o_Ch_Reset`=11 after edge E5.
  - Channel 0 is released after E6.
  - Channel 1 is released after E8; `o_Run`=1 and `o_Cycle_Count`=0 after E8.
- General formula: channel k is released after edge PRE_CYCLES + PULSE_CYCLES + k·STAGGER.
- Halt latency: `i_Halt` sampled at edge N gives `o_Done`=1 after edge N. `o_Cycle_Count` freezes at its value after N.
- Timeout: `o_Done`=`o_Timeout`=1 one edge after the count reaches TIMEOUT_CYCLES−1. The frozen count is TIMEOUT_CYCLES−1.
- `i_Reset` asserted mid-operation clears all outputs immediately, without waiting for a clock edge.

## Configuration
- Macro: `RSEQ_WATCHDOG_EN`.
- Defined: the watchdog compare is built and `o_Timeout` behaves as above.
- Undefined:
  - The compare logic is removed and `o_Timeout` is tied to 0.
  - RUN exits only on `i_Halt` or `i_Start`.
  - The counter still saturates.

## Structure
- Shared package/include `lc3_sim_pkg` holds:
  - the state encodings (PRE, ASSERT, RELEASE, RUN, DONE);
  - the default parameter constants.
- One sub-module, `sat_counter`: a parametrised CNT_W up-counter with clear, enable and saturation. It is instantiated twice, once as the phase counter and once as the run counter.
- The release-mask generation stays in the top-level block.

## Test plan
- Defaults, `i_Reset` pulsed then released → `o_Ch_Reset` 00→11 after E5, 10 after E6, 00 after E8; `o_Run`=1 after E8.
- `i_Halt` pulsed at run cycle 40 → `o_Done`=1, `o_Cycle_Count`=40 frozen, `o_Timeout`=0.
- No halt, `RSEQ_WATCHDOG_EN` defined → `o_Done`=`o_Timeout`=1 with count 249. The same stimulus with the macro undefined → count saturates, `o_Done` stays 0.
- `i_Halt` asserted exactly when the count reaches 249 → `o_Done`=1, `o_Timeout`=0.
- `i_Start` during RELEASE after E7 → `o_Ch_Reset`=11 on the next edge, state=PRE, and the full sequence repeats with identical relative timing.
- `i_Reset` asserted during RUN between clock edges → all outputs 0 immediately; after release, the sequence restarts from PRE.
